// File: rtl/uart_tx_loader.sv
// uart_tx_loader: buffered, flow-controlled Tx front end feeding the Tx FIFO
// from the system write port, with optional parity, overflow flag and flush.
//
// Ports:
//   baud_clk    clock, all state changes on its rising edge
//   rst         synchronous active-low reset
//   write       load request, data_in sampled while high
//   data_in     word to transmit (DATA_W bits)
//   wr_ready    staging queue not full
//   TxFF        Tx FIFO full, blocks pushes while high
//   fifo_wdata  word to Tx FIFO, parity in MSB when PARITY != 0
//   fifo_push   registered single-cycle push strobe
//   level       staging occupancy
//   overflow    sticky dropped-write flag
//   clr_ovf     clears overflow (a same-cycle drop wins)
//   flush       discards staged words, beats accept and pop
module uart_tx_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int PARITY = 0,
  localparam int OUT_W = DATA_W + ((PARITY != 0) ? 1 : 0),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_ready,
  input  logic              TxFF,
  output logic [OUT_W-1:0]  fifo_wdata,
  output logic              fifo_push,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clr_ovf,
  input  logic              flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_count;
  logic [OUT_W-1:0]  r_wdata;
  logic              r_push;
  logic              r_ovf;

  logic              w_full;
  logic              w_empty;
  logic              w_acc;
  logic              w_drop;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [OUT_W-1:0]  w_out;

  // Fullness comes from the registered count, so a pop in
  // the same cycle cannot make room for a write.
  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);

  assign w_acc  = write & ~w_full & ~flush;
  assign w_drop = write &  w_full & ~flush;
  assign w_pop  = ~w_empty & ~TxFF & ~flush;

  assign w_head = r_mem[r_rd_ptr];

  generate
    if (PARITY != 0) begin : g_par
      logic w_par;
      assign w_par = (PARITY == 2) ? ~^w_head : ^w_head;
      assign w_out = {w_par, w_head};
    end else begin : g_nopar
      assign w_out = w_head;
    end
  endgenerate

  // Storage needs no reset: only entries between the
  // pointers are ever read out.
  always_ff @(posedge baud_clk) begin
    if (w_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_acc && !w_pop) begin
        r_count <= r_count + LVL_ONE;
      end else if (w_pop && !w_acc) begin
        r_count <= r_count - LVL_ONE;
      end
    end
  end

  // Output word holds between pushes; strobe lasts one cycle.
  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      r_push  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_push <= w_pop;
      if (w_pop) begin
        r_wdata <= w_out;
      end
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign wr_ready   = ~w_full;
  assign fifo_wdata = r_wdata;
  assign fifo_push  = r_push;
  assign level      = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_loader.sv
// tb_uart_tx_loader: three loaders (no/even/odd parity) on shared stimulus,
// checked every cycle against a queue-based reference model.
module tb_uart_tx_loader;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       write;
  logic [7:0] data_in;
  logic       TxFF;
  logic       flush;
  logic       clr_ovf;

  logic       rdy0, rdy1, rdy2;
  logic       push0, push1, push2;
  logic       ovf0, ovf1, ovf2;
  logic [2:0] lvl0, lvl1, lvl2;
  logic [7:0] wd0;
  logic [8:0] wd1, wd2;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  bit         m_push;
  bit         m_ovf;
  logic [7:0] m_w0;
  logic [8:0] m_w1;
  logic [8:0] m_w2;

  always #5 baud_clk = ~baud_clk;

  uart_tx_loader #(.DATA_W(8), .DEPTH(4), .PARITY(0)) u_p0 (
    .baud_clk(baud_clk), .rst(rst), .write(write), .data_in(data_in),
    .wr_ready(rdy0), .TxFF(TxFF), .fifo_wdata(wd0), .fifo_push(push0),
    .level(lvl0), .overflow(ovf0), .clr_ovf(clr_ovf), .flush(flush)
  );

  uart_tx_loader #(.DATA_W(8), .DEPTH(4), .PARITY(1)) u_p1 (
    .baud_clk(baud_clk), .rst(rst), .write(write), .data_in(data_in),
    .wr_ready(rdy1), .TxFF(TxFF), .fifo_wdata(wd1), .fifo_push(push1),
    .level(lvl1), .overflow(ovf1), .clr_ovf(clr_ovf), .flush(flush)
  );

  uart_tx_loader #(.DATA_W(8), .DEPTH(4), .PARITY(2)) u_p2 (
    .baud_clk(baud_clk), .rst(rst), .write(write), .data_in(data_in),
    .wr_ready(rdy2), .TxFF(TxFF), .fifo_wdata(wd2), .fifo_push(push2),
    .level(lvl2), .overflow(ovf2), .clr_ovf(clr_ovf), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: a word queue of capacity 4 applied with the
  // rules flush > (pop head, then accept if not full at start).
  task automatic model_step();
    logic [7:0] h;
    bit full;
    bit pop;
    if (!rst) begin
      mq.delete();
      m_push = 0;
      m_ovf = 0;
      m_w0 = '0;
      m_w1 = '0;
      m_w2 = '0;
    end else if (flush) begin
      mq.delete();
      m_push = 0;
      if (clr_ovf) m_ovf = 0;
    end else begin
      full = (mq.size() == 4);
      pop = (mq.size() > 0) && !TxFF;
      m_push = pop;
      if (pop) begin
        h = mq.pop_front();
        m_w0 = h;
        m_w1 = {^h, h};
        m_w2 = {~^h, h};
      end
      if (write && !full) mq.push_back(data_in);
      if (write && full) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  endtask

  task automatic check_all();
    logic [2:0] el;
    el = 3'(mq.size());
    chk("level0", 32'(lvl0), 32'(el));
    chk("level1", 32'(lvl1), 32'(el));
    chk("level2", 32'(lvl2), 32'(el));
    chk("wr_ready", 32'({rdy0, rdy1, rdy2}),
        32'({3{el != 3'd4}}));
    chk("overflow", 32'({ovf0, ovf1, ovf2}), 32'({3{m_ovf}}));
    chk("push", 32'({push0, push1, push2}), 32'({3{m_push}}));
    chk("wdata_p0", 32'(wd0), 32'(m_w0));
    chk("wdata_p1", 32'(wd1), 32'(m_w1));
    chk("wdata_p2", 32'(wd2), 32'(m_w2));
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit ff,
                     input bit fl = 0, input bit clr = 0, input bit r = 1);
    write = w;
    data_in = d;
    TxFF = ff;
    flush = fl;
    clr_ovf = clr;
    rst = r;
    model_step();
    @(posedge baud_clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [8:0] ex[4];
    ex[0] = 9'h101;
    ex[1] = 9'h102;
    ex[2] = 9'h003;
    ex[3] = 9'h104;
    rst = 0;
    write = 0;
    data_in = '0;
    TxFF = 0;
    flush = 0;
    clr_ovf = 0;

    // reset
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("rst_level", 32'(lvl1), 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd1);
    chk("rst_wdata", 32'(wd2), 32'd0);

    // single write: push two cycles later
    cyc(1, 8'h07, 0);
    chk("single_lvl", 32'(lvl1), 32'd1);
    chk("single_nopush", 32'(push1), 32'd0);
    cyc(0, 8'h00, 0);
    chk("single_push", 32'(push1), 32'd1);
    chk("single_wd", 32'(wd1), 32'h107);
    chk("single_lvl0", 32'(lvl1), 32'd0);
    cyc(0, 8'h00, 0);
    chk("single_one", 32'(push1), 32'd0);

    // fill, overflow, drain
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 1);
    chk("fill_lvl", 32'(lvl1), 32'd4);
    chk("fill_rdy", 32'(rdy1), 32'd0);
    chk("fill_ovf", 32'(ovf1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 0);
      chk("drain_push", 32'(push1), 32'd1);
      chk("drain_wd", 32'(wd1), 32'(ex[i]));
    end
    cyc(0, 8'h00, 0);
    chk("drain_end", 32'(push1), 32'd0);

    // flush with write in same cycle
    for (int i = 0; i < 3; i++) cyc(1, 8'h20 + 8'(i), 1);
    cyc(1, 8'hAA, 1, 1);
    chk("flush_lvl", 32'(lvl1), 32'd0);
    chk("flush_ovf", 32'(ovf1), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0);

    // overflow clear priority
    cyc(0, 8'h00, 1, 0, 1);
    chk("clr_alone", 32'(ovf1), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h30 + 8'(i), 1);
    cyc(1, 8'h3F, 1, 0, 1);
    chk("clr_vs_drop", 32'(ovf1), 32'd1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("clr_later", 32'(ovf1), 32'd0);
    cyc(0, 8'h00, 1, 1);

    // simultaneous write and pop across pointer wrap
    cyc(1, 8'h10, 1);
    cyc(1, 8'h11, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 8'h12 + 8'(i), 0);
      chk("wrap_lvl", 32'(lvl1), 32'd2);
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0);

    // reset mid-stream, then odd parity
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 1);
    cyc(1, 8'h43, 0);
    chk("mid_push", 32'(push1), 32'd1);
    chk("mid_lvl", 32'(lvl1), 32'd3);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("mid_rst_push", 32'(push1), 32'd0);
    chk("mid_rst_lvl", 32'(lvl1), 32'd0);
    chk("mid_rst_wd", 32'(wd1), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0);
    cyc(1, 8'h07, 0);
    cyc(0, 8'h00, 0);
    chk("odd_wd", 32'(wd2), 32'h007);
    chk("odd_push", 32'(push2), 32'd1);
    cyc(0, 8'h00, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(9) < 7, 8'($urandom), $urandom_range(9) < 3,
          $urandom_range(39) == 0, $urandom_range(19) == 0,
          $urandom_range(99) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_loader.md
# uart_tx_loader

Parametrised UART transmit-side loader between the system write port and the Tx FIFO, clocked by `baud_clk`. It accepts parallel words through a write strobe and buffers them in a small internal staging queue. It pushes them into the Tx FIFO one word per cycle, only while the FIFO reports not-full, and can append a parity bit to each word. It replaces the single-register Tx front end with a buffered, flow-controlled version that has overflow reporting and flush.

## Interface
- `DATA_W`, 8, payload width; legal range 5–9.
- `DEPTH`, 4, staging queue entries; power of two, ≥2.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `OUT_W` (derived), DATA_W + (PARITY != 0).
- `LVL_W` (derived), $clog2(DEPTH+1).

Ports:
- `baud_clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `write`  in  1  load request; `data_in` is sampled when high.
- `data_in`  in  DATA_W  word to transmit.
- `wr_ready`  out  1  staging queue not full (level < DEPTH).
- `TxFF`  in  1  Tx FIFO full; while high, no push is issued.
- `fifo_wdata`  out  OUT_W  word presented to the Tx FIFO; parity bit in the MSB when PARITY≠0.
- `fifo_push`  out  1  single-cycle push strobe, registered.
- `level`  out  LVL_W  current staging occupancy.
- `overflow`  out  1  sticky: a write was dropped.
- `clr_ovf`  in  1  clears `overflow`.
- `flush`  in  1  discards the staging contents.

## Operation
- The staging queue is circular, with rd/wr pointers of $clog2(DEPTH) bits that wrap naturally, plus a count register driving `level`.
- Accept: if `write` && `level` < DEPTH && !`flush`, then `data_in` is stored at wr_ptr and wr_ptr increments.
- Drop: if `write` && `level` == DEPTH && !`flush`, the word is discarded and `overflow` is set. A pop in the same cycle does not rescue the write, because `wr_ready` is based on the registered level.
- Pop: if `level` > 0 && !`TxFF` && !`flush`, the head word is registered into `fifo_wdata`, `fifo_push` goes to 1 for the next cycle, and rd_ptr increments. Otherwise `fifo_push` goes to 0 and `fifo_wdata` holds its value.
- Accept and pop in the same cycle leave `level` unchanged; FIFO order is preserved.
- Parity is computed at pop.
  - PARITY=1: parity bit = ^word.
  - PARITY=2: parity bit = ~^word.
  - PARITY=0: `fifo_wdata` = word.
- Flush takes priority over accept and pop.
  - Pointers and count go to 0 and `fifo_push` goes to 0.
  - A `write` in the flush cycle is ignored and is not counted as an overflow.
  - `overflow` is unaffected by flush.
- `overflow`: a set event and `clr_ovf` in the same cycle leave it at 1 (set wins). `clr_ovf` alone clears it to 0.
- `wr_ready` = (`level` != DEPTH), combinational from the count register.

## Timing
- Reset values (cycle after `rst` is sampled low): `fifo_push` 0, `fifo_wdata` 0, `level` 0, `overflow` 0, `wr_ready` 1.
- Reset mid-operation discards all staged words. No push occurs from pre-reset contents.
- Latency: `write` high in cycle k with an empty queue and `TxFF` low in cycle k+1 gives `fifo_push` high in cycle k+2.
- Throughput: one push per cycle while `level` > 0 and `TxFF` stays low.
- `TxFF` is sampled in the pop-decision cycle, and the push lands one cycle later. The Tx FIFO therefore asserts `TxFF` with at least one free entry of headroom. The loader issues at most one push after `TxFF` rises.
- `level` updates one cycle after the accept or pop event. `overflow` is set one cycle after the dropped write.

## Test plan
- Single write, with DATA_W=8, DEPTH=4, PARITY=1:
  - Stimulus: reset, then `write` one cycle with `data_in`=0x07 and `TxFF`=0.
  - Response: `fifo_push`=1 exactly two cycles later for one cycle, with `fifo_wdata`=9'h107. `level` goes 0→1→0.
- Fill, overflow and drain:
  - Stimulus: `TxFF`=1, then write 0x01, 0x02, 0x03, 0x04 and 0x05 on consecutive cycles.
  - Response: `level`=4, `wr_ready`=0, `overflow`=1, no push.
  - Then drop `TxFF`: pushes on 4 consecutive cycles are 9'h101, 9'h102, 9'h003, 9'h104; 0x05 never appears.
- Simultaneous write and pop:
  - Stimulus: `level`=2, `TxFF`=0, write 0x10 while the head is popped.
  - Response: `level` stays 2, and pop order is preserved through pointer wrap over more than 8 words.
- Flush:
  - Stimulus: `level`=3 with `overflow`=1; `flush` and `write`=1 with 0xAA in the same cycle.
  - Response: `level`=0 next cycle, no push, `overflow` stays 1, and 0xAA is never pushed.
- Overflow clear priority:
  - Stimulus: `clr_ovf` in the same cycle as a dropped write.
  - Response: `overflow` stays 1. `clr_ovf` alone on a later cycle gives `overflow`=0.
- Reset mid-stream and odd parity:
  - Stimulus: `rst`=0 while `level`=3 and `fifo_push`=1.
  - Response: all outputs at reset values next cycle, and no stale pushes after release.
  - Repeat with PARITY=2: `data_in`=0x07 pushes 9'h007.
